// File: rtl/sudoku_pkg.sv
// Shared constants for the Sudoku board front end.
// Button indices, repeat-FSM state encoding and a counter-width helper.
package sudoku_pkg;

  localparam int NUM_BUTTONS = 5;

  localparam int BTN_UP    = 0;
  localparam int BTN_DN    = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_WRITE = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce, registered press pulse and optional repeat FSM.
// Press pulse and debounced level change on the same edge; repeat pulses follow while held.
module button_channel
  import sudoku_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 250000,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 5000000,
  parameter bit REPEAT_ALLOWED      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic held
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          press;
  logic          rpt_pulse;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Press is seen on the same edge the level rises, so pulse and held line up.
  assign press   = stable_d & ~stable_q;
  assign pulse_d = press | rpt_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  generate
    if (REPEAT_ALLOWED) begin : g_rpt
      localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
      localparam int RW = cnt_width(RMAX);
      localparam logic [RW-1:0] DELAY_MAX = RW'(REPEAT_DELAY_CYCLES - 1);
      localparam logic [RW-1:0] RATE_MAX  = RW'(REPEAT_RATE_CYCLES - 1);

      rpt_state_e    state_q, state_d;
      logic [RW-1:0] rcnt_q, rcnt_d;
      logic          rpt_d;

      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rpt_d   = 1'b0;
        // Release wins over a repeat due on the same edge.
        if (!stable_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else begin
          case (state_q)
            IDLE: begin
              if (press) begin
                state_d = DELAY;
                rcnt_d  = '0;
              end
            end
            DELAY: begin
              if (rcnt_q == DELAY_MAX) begin
                rpt_d   = 1'b1;
                state_d = REPEAT;
                rcnt_d  = '0;
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
            REPEAT: begin
              if (rcnt_q == RATE_MAX) begin
                rpt_d  = 1'b1;
                rcnt_d = '0;
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
            default: begin
              state_d = IDLE;
              rcnt_d  = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end

      assign rpt_pulse = rpt_d;
    end else begin : g_no_rpt
      assign rpt_pulse = 1'b0;
    end
  endgenerate

  assign pulse = pulse_q;
  assign held  = stable_q;

endmodule

// File: rtl/button_conditioner.sv
// Five independent button channels feeding interfaceController; heldMask = {write,right,left,dn,up}.
// Auto-repeat on the navigation buttons is built only when BUTTON_AUTOREPEAT_EN is defined.
module button_conditioner
  import sudoku_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 250000,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 5000000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   rawUp,
  input  logic                   rawDn,
  input  logic                   rawLeft,
  input  logic                   rawRight,
  input  logic                   rawWrite,
  output logic                   upButton,
  output logic                   dnButton,
  output logic                   leftButton,
  output logic                   rightButton,
  output logic                   writeBit,
  output logic [NUM_BUTTONS-1:0] heldMask
);

`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic [NUM_BUTTONS-1:0] raw_vec;
  logic [NUM_BUTTONS-1:0] pulse_vec;

  assign raw_vec[BTN_UP]    = rawUp;
  assign raw_vec[BTN_DN]    = rawDn;
  assign raw_vec[BTN_LEFT]  = rawLeft;
  assign raw_vec[BTN_RIGHT] = rawRight;
  assign raw_vec[BTN_WRITE] = rawWrite;

  // Write must never repeat, so its channel is always built without the FSM.
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
      .REPEAT_ALLOWED     (AUTOREPEAT && (i != BTN_WRITE))
    ) u_ch (
      .clk  (CLK),
      .rst  (RST),
      .raw  (raw_vec[i]),
      .pulse(pulse_vec[i]),
      .held (heldMask[i])
    );
  end

  assign upButton    = pulse_vec[BTN_UP];
  assign dnButton    = pulse_vec[BTN_DN];
  assign leftButton  = pulse_vec[BTN_LEFT];
  assign rightButton = pulse_vec[BTN_RIGHT];
  assign writeBit    = pulse_vec[BTN_WRITE];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: window-based reference model checked every cycle plus literal timing checks.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       rawUp = 1'b0, rawDn = 1'b0, rawLeft = 1'b0, rawRight = 1'b0, rawWrite = 1'b0;
  logic       upButton, dnButton, leftButton, rightButton, writeBit;
  logic [4:0] heldMask;

  int checks = 0;
  int errors = 0;
  int pc [5];

  always #5 CLK = ~CLK;

  button_conditioner #(
    .DEBOUNCE_CYCLES    (DB),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES (RR)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .rawUp      (rawUp),
    .rawDn      (rawDn),
    .rawLeft    (rawLeft),
    .rawRight   (rawRight),
    .rawWrite   (rawWrite),
    .upButton   (upButton),
    .dnButton   (dnButton),
    .leftButton (leftButton),
    .rightButton(rightButton),
    .writeBit   (writeBit),
    .heldMask   (heldMask)
  );

  wire [4:0] raw    = {rawWrite, rawRight, rawLeft, rawDn, rawUp};
  wire [4:0] pulses = {writeBit, rightButton, leftButton, dnButton, upButton};

  // Model: the level flips once the last DB synchronised samples all disagree with it;
  // repeats are scheduled arithmetically from the press edge.
  logic [4:0] hist [DB+2];
  logic [4:0] m_held  = '0;
  logic [4:0] m_pulse = '0;
  int         since [5];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < DB + 2; k++) hist[k] = '0;
      m_held  = '0;
      m_pulse = '0;
      for (int b = 0; b < 5; b++) since[b] = 0;
    end else begin
      for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = raw;
      for (int b = 0; b < 5; b++) begin
        logic all_diff;
        logic nxt;
        all_diff = 1'b1;
        for (int k = 2; k <= DB + 1; k++)
          if (hist[k][b] == m_held[b]) all_diff = 1'b0;
        nxt = all_diff ? ~m_held[b] : m_held[b];
        m_pulse[b] = nxt & ~m_held[b];
        if (m_pulse[b]) since[b] = 0;
        else if (nxt) since[b] = since[b] + 1;
        if (!m_pulse[b] && nxt && AR && b != 4 && since[b] >= RD && ((since[b] - RD) % RR) == 0)
          m_pulse[b] = 1'b1;
        m_held[b] = nxt;
      end
    end
  end

  always @(negedge CLK) begin
    checks++;
    if ({pulses, heldMask} !== {m_pulse, m_held}) begin
      errors++;
      $display("FAIL model_cycle t=%0t pulses=%b heldMask=%b expected pulses=%b heldMask=%b",
               $time, pulses, heldMask, m_pulse, m_held);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      for (int b = 0; b < 5; b++) pc[b] += int'(pulses[b]);
    end
  endtask

  task automatic clr();
    for (int b = 0; b < 5; b++) pc[b] = 0;
  endtask

  initial begin
    clr();
    #1 RST = 1'b1;
    tick(3);
    chk("reset_held", 32'(heldMask), 32'h0);
    chk("reset_pulses", 32'(pulses), 32'h0);
    RST = 1'b0;
    tick(5);

    // Clean up press: pulse in the cycle after edge 6.
    clr();
    rawUp = 1'b1;
    tick(5);
    chk("up_e5", 32'({pulses, heldMask}), 32'h0);
    tick(1);
    chk("up_e6_pulse", 32'(pulses), 32'h01);
    chk("up_e6_held", 32'(heldMask), 32'h01);
    tick(1);
    chk("up_e7_pulse", 32'(pulses), 32'h0);
    rawUp = 1'b0;
    tick(12);
    chk("up_count", 32'(pc[0]), 32'd1);
    chk("up_released", 32'(heldMask), 32'h0);

    // Bounce: 3 high, 1 low, then steady high.
    clr();
    rawLeft = 1'b1;
    tick(3);
    rawLeft = 1'b0;
    tick(1);
    rawLeft = 1'b1;
    tick(5);
    chk("left_e5", 32'(leftButton), 32'd0);
    tick(1);
    chk("left_e6", 32'(leftButton), 32'd1);
    chk("left_held", 32'(heldMask), 32'h04);
    tick(1);
    rawLeft = 1'b0;
    tick(12);
    chk("left_count", 32'(pc[2]), 32'd1);

    // Dn held 30 cycles past its press pulse.
    clr();
    rawDn = 1'b1;
    tick(16);
    chk("dn_rep_p10", 32'(dnButton), 32'(AR));
    tick(1);
    chk("dn_p11", 32'(dnButton), 32'd0);
    tick(2);
    chk("dn_rep_p13", 32'(dnButton), 32'(AR));
    tick(17);
    rawDn = 1'b0;
    tick(5);
    chk("dn_rel_e5", 32'(heldMask[1]), 32'd1);
    tick(1);
    chk("dn_rel_e6", 32'(heldMask[1]), 32'd0);
    tick(6);
    chk("dn_count", 32'(pc[1]), AR ? 32'd10 : 32'd1);

    // Write never repeats.
    clr();
    rawWrite = 1'b1;
    tick(50);
    rawWrite = 1'b0;
    tick(10);
    chk("write_count", 32'(pc[4]), 32'd1);

    clr();
    rawRight = 1'b1;
    tick(40);
    rawRight = 1'b0;
    tick(10);
    chk("right_count", 32'(pc[3]), AR ? 32'd11 : 32'd1);

    // Simultaneous presses.
    clr();
    rawUp = 1'b1;
    rawRight = 1'b1;
    tick(6);
    chk("simul_pulses", 32'(pulses), 32'h09);
    chk("simul_held", 32'(heldMask), 32'h09);
    tick(1);
    rawUp = 1'b0;
    rawRight = 1'b0;
    tick(10);
    chk("simul_up_count", 32'(pc[0]), 32'd1);
    chk("simul_right_count", 32'(pc[3]), 32'd1);

    // Asynchronous reset mid-repeat with the button still held.
    clr();
    rawDn = 1'b1;
    tick(20);
    chk("pre_reset_held", 32'(heldMask), 32'h02);
    #2 RST = 1'b1;
    #1;
    chk("async_reset_held", 32'(heldMask), 32'h0);
    chk("async_reset_pulses", 32'(pulses), 32'h0);
    tick(2);
    RST = 1'b0;
    tick(5);
    chk("post_reset_e5", 32'({dnButton, heldMask[1]}), 32'd0);
    tick(1);
    chk("post_reset_e6_pulse", 32'(dnButton), 32'd1);
    chk("post_reset_e6_held", 32'(heldMask), 32'h02);
    tick(1);
    rawDn = 1'b0;
    tick(12);
    chk("final_idle", 32'(heldMask), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
